// File: rtl/alu_pkg.sv
// Shared ALU op encoding, used by the combinational ALU and the divide unit.
// Ports: none (package). Holds the ALU_* op localparams and a decode helper.
// The divide/remainder group occupies codes 5'b01110..5'b10001.
package alu_pkg;

  localparam int NB_ALU_CTRL = 5;

  localparam logic [NB_ALU_CTRL-1:0] ALU_ADD  = 5'b00000;
  localparam logic [NB_ALU_CTRL-1:0] ALU_SUB  = 5'b00001;
  localparam logic [NB_ALU_CTRL-1:0] ALU_AND  = 5'b00010;
  localparam logic [NB_ALU_CTRL-1:0] ALU_OR   = 5'b00011;
  localparam logic [NB_ALU_CTRL-1:0] ALU_XOR  = 5'b00100;
  localparam logic [NB_ALU_CTRL-1:0] ALU_SLL  = 5'b00101;
  localparam logic [NB_ALU_CTRL-1:0] ALU_SRL  = 5'b00110;
  localparam logic [NB_ALU_CTRL-1:0] ALU_SRA  = 5'b00111;
  localparam logic [NB_ALU_CTRL-1:0] ALU_SLT  = 5'b01000;
  localparam logic [NB_ALU_CTRL-1:0] ALU_SLTU = 5'b01001;
  localparam logic [NB_ALU_CTRL-1:0] ALU_LUI  = 5'b01010;
  localparam logic [NB_ALU_CTRL-1:0] ALU_MUL  = 5'b01011;
  localparam logic [NB_ALU_CTRL-1:0] ALU_MULH = 5'b01100;
  localparam logic [NB_ALU_CTRL-1:0] ALU_MULHU = 5'b01101;
  localparam logic [NB_ALU_CTRL-1:0] ALU_DIV  = 5'b01110;
  localparam logic [NB_ALU_CTRL-1:0] ALU_DIVU = 5'b01111;
  localparam logic [NB_ALU_CTRL-1:0] ALU_REM  = 5'b10000;
  localparam logic [NB_ALU_CTRL-1:0] ALU_REMU = 5'b10001;

  function automatic logic is_div_op(input logic [NB_ALU_CTRL-1:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit (radix-2 restoring, one bit per clock).
// Ports: i_clk/i_rst (sync, active-high), i_start/i_flush/i_alu_op/i_data1/i_data2 in;
//        o_result (qualify with o_valid), o_valid (1-cycle pulse), o_busy (state != IDLE).
module div_unit
  import alu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_CTRL = 5,
  parameter int NB_CNT  = $clog2(NB_DATA)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_flush,
  input  logic [NB_CTRL-1:0] i_alu_op,
  input  logic [NB_DATA-1:0] i_data1,
  input  logic [NB_DATA-1:0] i_data2,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_valid,
  output logic               o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [NB_DATA-1:0] MIN_NEG  = {1'b1, {(NB_DATA-1){1'b0}}};
  localparam logic [NB_CNT-1:0]  CNT_LAST = NB_CNT'(NB_DATA-1);

  state_t              state;
  logic [NB_CNT-1:0]   cnt;
  logic                op_rem;   // latched: remainder wanted instead of quotient
  logic                neg_q;    // latched: quotient must be negated
  logic                neg_r;    // latched: remainder must be negated
  logic [NB_DATA-1:0]  dvsr;     // |divisor|
  logic [NB_DATA-1:0]  quo;      // shifts dividend bits out, quotient bits in
  logic [NB_DATA:0]    rem;      // partial remainder, one guard bit

  // Decode of the incoming request (only meaningful in IDLE)
  logic               in_valid_op, in_signed, in_rem, a_neg, b_neg;
  logic               div_zero, sgn_ovf;
  logic [NB_DATA-1:0] a_mag, b_mag, special_res;

  always_comb begin
    in_valid_op = is_div_op(i_alu_op);
    in_signed   = (i_alu_op == ALU_DIV) || (i_alu_op == ALU_REM);
    in_rem      = (i_alu_op == ALU_REM) || (i_alu_op == ALU_REMU);
    a_neg       = in_signed & i_data1[NB_DATA-1];
    b_neg       = in_signed & i_data2[NB_DATA-1];
    a_mag       = a_neg ? -i_data1 : i_data1;
    b_mag       = b_neg ? -i_data2 : i_data2;
    div_zero    = (i_data2 == '0);
    sgn_ovf     = in_signed && (i_data1 == MIN_NEG) && (i_data2 == '1);
    // Divide-by-zero takes precedence; the raw dividend is the remainder.
    if (div_zero)
      special_res = in_rem ? i_data1 : '1;
    else
      special_res = in_rem ? '0 : MIN_NEG;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract on NB_DATA+1 bits.
  logic [NB_DATA:0]   rem_sh, diff, rem_nxt;
  logic               q_bit;
  logic [NB_DATA-1:0] quo_nxt, q_fix, r_fix;

  always_comb begin
    rem_sh  = {rem[NB_DATA-1:0], quo[NB_DATA-1]};
    diff    = rem_sh - {1'b0, dvsr};
    q_bit   = ~diff[NB_DATA];
    rem_nxt = q_bit ? diff : rem_sh;
    quo_nxt = {quo[NB_DATA-2:0], q_bit};
    q_fix   = neg_q ? -quo_nxt : quo_nxt;
    r_fix   = neg_r ? -rem_nxt[NB_DATA-1:0] : rem_nxt[NB_DATA-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvsr     <= '0;
      quo      <= '0;
      rem      <= '0;
      o_result <= '0;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start && in_valid_op && !i_flush) begin
            op_rem <= in_rem;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dvsr   <= b_mag;
            quo    <= a_mag;
            rem    <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            if (div_zero || sgn_ovf) begin
              o_result <= special_res;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (i_flush) begin
            state  <= S_IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (cnt == CNT_LAST) begin
              cnt      <= '0;
              o_result <= op_rem ? r_fix : q_fix;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          // DONE (or flush in DONE): always back to IDLE, new starts are not taken here.
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [4:0]  alu_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] result;
  logic        valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_flush (flush),
    .i_alu_op(alu_op),
    .i_data1 (data1),
    .i_data2 (data2),
    .o_result(result),
    .o_valid (valid),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the negedge of the first cycle after the start edge.
  task automatic drive_start(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    alu_op = op;
    data1  = a;
    data2  = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for o_valid; lat counts cycles after the start edge.
  task automatic wait_valid(input int lat0, output int lat, output logic [31:0] res);
    lat = lat0;
    while (!valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  // Count o_valid pulses over n cycles.
  task automatic watch_valid(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (valid) seen++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; data1 = '0; data2 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({result, valid, busy} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_state: result=%h valid=%b busy=%b, required 0/0/0", result, valid, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_divu;
    int lat; logic [31:0] res;
    drive_start(ALU_DIVU, 32'd100, 32'd7);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL divu_busy_rise: busy=%b required 1", busy); end
    wait_valid(1, lat, res);
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d required 33", lat); end
    n_checks++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %h required %h", res, 32'd14); end
    @(negedge clk);
    n_checks++;
    if ({busy, valid} !== 2'b00) begin
      n_fail++; $display("FAIL divu_after: busy=%b valid=%b required 0/0", busy, valid);
    end
  endtask

  task automatic test_signed;
    logic [4:0]  ops [3] = '{ALU_DIV, ALU_REM, ALU_REMU};
    logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0001};
    int lat; logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      drive_start(ops[i], 32'hFFFF_FFF9, 32'd2);
      wait_valid(1, lat, res);
      n_checks++;
      if (lat !== 33 || res !== exp[i]) begin
        n_fail++;
        $display("FAIL signed_%0d: lat=%0d result=%h required lat=33 result=%h", i, lat, res, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    logic [4:0]  ops [2] = '{ALU_DIVU, ALU_REM};
    logic [31:0] exp [2] = '{32'hFFFF_FFFF, 32'd5};
    for (int i = 0; i < 2; i++) begin
      drive_start(ops[i], 32'd5, 32'd0);
      n_checks++;
      if (valid !== 1'b1 || busy !== 1'b1 || result !== exp[i]) begin
        n_fail++;
        $display("FAIL div_zero_%0d: valid=%b busy=%b result=%h required 1/1/%h", i, valid, busy, result, exp[i]);
      end
      @(negedge clk);
      n_checks++;
      if ({busy, valid} !== 2'b00) begin
        n_fail++; $display("FAIL div_zero_%0d_after: busy=%b valid=%b required 0/0", i, busy, valid);
      end
    end
  endtask

  task automatic test_overflow;
    logic [4:0]  ops [2] = '{ALU_REM, ALU_DIV};
    logic [31:0] exp [2] = '{32'h0, 32'h8000_0000};
    for (int i = 0; i < 2; i++) begin
      drive_start(ops[i], 32'h8000_0000, 32'hFFFF_FFFF);
      n_checks++;
      if (valid !== 1'b1 || result !== exp[i]) begin
        n_fail++;
        $display("FAIL overflow_%0d: valid=%b result=%h required 1/%h", i, valid, result, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush;
    int lat, seen; logic [31:0] res, prev;
    prev = result;
    drive_start(ALU_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if ({busy, valid} !== 2'b00 || result !== prev) begin
      n_fail++;
      $display("FAIL flush_calc: busy=%b valid=%b result=%h required 0/0/%h", busy, valid, result, prev);
    end
    watch_valid(40, seen);
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_no_valid: pulses=%0d required 0", seen); end
    // flush in IDLE beats a same-cycle start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; alu_op = ALU_DIVU; data1 = 32'd9; data2 = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_blocks: busy=%b required 0", busy); end
    watch_valid(40, seen);
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_idle_no_valid: pulses=%0d required 0", seen); end
    drive_start(ALU_DIVU, 32'd9, 32'd3);
    wait_valid(1, lat, res);
    n_checks++;
    if (lat !== 33 || res !== 32'd3) begin
      n_fail++; $display("FAIL flush_restart: lat=%0d result=%h required 33/%h", lat, res, 32'd3);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, seen; logic [31:0] res;
    drive_start(ALU_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; alu_op = ALU_DIVU; data1 = 32'd50; data2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_valid(6, lat, res);
    n_checks++;
    if (lat !== 33 || res !== 32'd14) begin
      n_fail++; $display("FAIL start_while_busy: lat=%0d result=%h required 33/%h", lat, res, 32'd14);
    end
    // start offered in DONE must be dropped
    start = 1'b1; alu_op = ALU_DIVU; data1 = 32'd9; data2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done: busy=%b required 0", busy); end
    watch_valid(40, seen);
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL start_in_done_valid: pulses=%0d required 0", seen); end
  endtask

  task automatic test_reset_mid;
    int seen;
    drive_start(ALU_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({result, valid, busy} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: result=%h valid=%b busy=%b required 0/0/0", result, valid, busy);
    end
    watch_valid(40, seen);
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_valid: pulses=%0d required 0", seen); end
  endtask

  task automatic test_bad_op;
    int seen;
    drive_start(ALU_ADD, 32'd100, 32'd7);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_op_busy: busy=%b required 0", busy); end
    watch_valid(40, seen);
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL bad_op_valid: pulses=%0d required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_bad_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
